// File: rtl/cp0_pkg.sv
// Shared CP0 exception-control definitions: FSM states, ExcCodes, CP0 register
// indices, mux encodings and the exception vector.
package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_HOLD  = 2'd2
  } cp0_state_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [1:0] SELPC_SEQ = 2'd0;
  localparam logic [1:0] SELPC_EPC = 2'd1;
  localparam logic [1:0] SELPC_VEC = 2'd2;

  localparam logic [1:0] MFC0_ALU = 2'd0;
  localparam logic [1:0] MFC0_STA = 2'd1;
  localparam logic [1:0] MFC0_CAU = 2'd2;
  localparam logic [1:0] MFC0_EPC = 2'd3;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0004;

  function automatic logic [31:0] cause_word(input logic [4:0] code);
    return {25'd0, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// Fixed-priority event selector for the EX stage: picks at most one of
// interrupt, ov, unimpl, syscall, eret, mtc0 and reports its ExcCode.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic       en_i,
  input  logic       ex_valid_i,
  input  logic       intr_i,
  input  logic       ov_i,
  input  logic       unimpl_i,
  input  logic       syscall_i,
  input  logic       eret_i,
  input  logic       mtc0_req_i,
  input  logic [3:0] sta_en_i,
  output logic       acc_int_o,
  output logic       acc_exc_o,
  output logic       acc_eret_o,
  output logic       acc_mtc0_o,
  output logic [4:0] exccode_o
);

  always_comb begin
    acc_int_o  = 1'b0;
    acc_exc_o  = 1'b0;
    acc_eret_o = 1'b0;
    acc_mtc0_o = 1'b0;
    exccode_o  = EXC_INT;
    if (en_i && ex_valid_i) begin
      if (intr_i && sta_en_i[0]) begin
        acc_int_o = 1'b1;
        acc_exc_o = 1'b1;
        exccode_o = EXC_INT;
      end else if (ov_i && sta_en_i[3]) begin
        acc_exc_o = 1'b1;
        exccode_o = EXC_OV;
      end else if (unimpl_i && sta_en_i[2]) begin
        acc_exc_o = 1'b1;
        exccode_o = EXC_RI;
      end else if (syscall_i && sta_en_i[1]) begin
        acc_exc_o = 1'b1;
        exccode_o = EXC_SYS;
      end else if (eret_i) begin
        acc_eret_o = 1'b1;
      end else if (mtc0_req_i) begin
        acc_mtc0_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: accepts one EX-stage event per cycle,
// drives CP0 write enables and PC redirect, then flushes for FLUSH_CYCLES.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr,
  input  logic        ex_valid,
  input  logic        ov,
  input  logic        unimpl,
  input  logic        syscall,
  input  logic        eret,
  input  logic        mfc0_req,
  input  logic        mtc0_req,
  input  logic [4:0]  c0_rd,
  input  logic [31:0] sta,
  output logic        wsta,
  output logic        wcau,
  output logic        wepc,
  output logic        exc,
  output logic        inta,
  output logic        mtc0,
  output logic [1:0]  mfc0,
  output logic [1:0]  selpc,
  output logic [31:0] cause,
  output logic        flush,
  output logic        busy
);

  localparam logic [2:0] HOLD_LEN = 3'(FLUSH_CYCLES - 1);

  cp0_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       armed_q;
  logic       run;
  logic       acc_int, acc_exc, acc_eret, acc_mtc0;
  logic [4:0] exccode;
  logic       unused_sta;

  assign unused_sta = ^sta[31:4];
  // Outputs stay quiet during reset and for one cycle after it is released.
  assign run = rst & armed_q;

  cp0_exc_prio u_prio (
    .en_i       (run && (state_q == ST_IDLE)),
    .ex_valid_i (ex_valid),
    .intr_i     (intr),
    .ov_i       (ov),
    .unimpl_i   (unimpl),
    .syscall_i  (syscall),
    .eret_i     (eret),
    .mtc0_req_i (mtc0_req),
    .sta_en_i   (sta[3:0]),
    .acc_int_o  (acc_int),
    .acc_exc_o  (acc_exc),
    .acc_eret_o (acc_eret),
    .acc_mtc0_o (acc_mtc0),
    .exccode_o  (exccode)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wsta    = 1'b0;
    wcau    = 1'b0;
    wepc    = 1'b0;
    exc     = 1'b0;
    inta    = 1'b0;
    mtc0    = 1'b0;
    mfc0    = MFC0_ALU;
    selpc   = SELPC_SEQ;
    cause   = 32'd0;
    flush   = 1'b0;
    busy    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        if (acc_exc) begin
          wsta    = 1'b1;
          wcau    = 1'b1;
          wepc    = 1'b1;
          exc     = 1'b1;
          inta    = acc_int;
          selpc   = SELPC_VEC;
          cause   = cause_word(exccode);
          flush   = 1'b1;
          state_d = ST_REDIR;
        end else if (acc_eret) begin
          wsta    = 1'b1;
          selpc   = SELPC_EPC;
          flush   = 1'b1;
          state_d = ST_REDIR;
        end else if (acc_mtc0) begin
          mtc0 = 1'b1;
          wsta = (c0_rd == CP0_STATUS);
          wcau = (c0_rd == CP0_CAUSE);
          wepc = (c0_rd == CP0_EPC);
        end
      end
      ST_REDIR: begin
        flush = 1'b1;
        busy  = 1'b1;
        if (HOLD_LEN == 3'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LEN;
        end
      end
      ST_HOLD: begin
        flush = 1'b1;
        busy  = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    if (mfc0_req && ex_valid) begin
      case (c0_rd)
        CP0_STATUS: mfc0 = MFC0_STA;
        CP0_CAUSE:  mfc0 = MFC0_CAU;
        CP0_EPC:    mfc0 = MFC0_EPC;
        default:    mfc0 = MFC0_ALU;
      endcase
    end

    if (!run) begin
      wsta  = 1'b0;
      wcau  = 1'b0;
      wepc  = 1'b0;
      exc   = 1'b0;
      inta  = 1'b0;
      mtc0  = 1'b0;
      mfc0  = MFC0_ALU;
      selpc = SELPC_SEQ;
      cause = 32'd0;
      flush = 1'b0;
      busy  = 1'b0;
    end
  end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: pipeline flush/hold cycles after any PC redirect (allowed range 1..7).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 intr  in  1  external interrupt request, level; held by source until inta.
REQ-005 ex_valid  in  1  EX-stage instruction valid (not bubble, not flushed).
REQ-006 ov, unimpl, syscall  in  1 each  EX-stage exception flags, qualified by ex_valid.
REQ-007 eret  in  1  EX-stage ERET decoded.
REQ-008 mfc0_req, mtc0_req  in  1 each  EX-stage MFC0/MTC0 decoded.
REQ-009 c0_rd  in  5  CP0 register index: 12 status, 13 cause, 14 epc.
REQ-010 sta  in  32  current status register; bits 0..3 are enables for intr, syscall, unimpl, ov.
REQ-011 wsta, wcau, wepc  out  1 each  CP0 register write enables.
REQ-012 exc  out  1  1 = shift status left 5 (entry); 0 = shift right 5 (return).
REQ-013 inta  out  1  interrupt acknowledge; also selects npc as EPC source.
REQ-014 mtc0  out  1  selects GP write data into CP0 registers.
REQ-015 mfc0  out  2  read select: 0 alu_mem, 1 status, 2 cause, 3 epc.
REQ-016 selpc  out  2  PC source: 0 sequential, 1 epc, 2 vector 0x0000_0004.
REQ-017 cause  out  32  cause value; ExcCode in bits 6:2, all other bits 0.
REQ-018 flush  out  1  flush IF/ID/EX stages.
REQ-019 busy  out  1  FSM not in IDLE.

Function
REQ-020 FSM states: IDLE, REDIR, HOLD; a 3-bit counter sizes HOLD.
REQ-021 In IDLE with ex_valid=1, the accepted event is chosen by priority intr&sta[0] > ov&sta[3] > unimpl&sta[2] > syscall&sta[1] > eret > mtc0_req; only one event per cycle.
REQ-022 Exception or interrupt accept, same cycle (Mealy): wsta=wcau=wepc=1, exc=1, mtc0=0, selpc=2, flush=1; next state REDIR.
REQ-023 Exception codes: interrupt 0, syscall 8, unimpl 10, ov 12; cause driven only during the accept cycle, 0 otherwise.
REQ-024 inta=1 for exactly the accept cycle of an interrupt, 0 for synchronous exceptions (EPC=pc).
REQ-025 ERET accept: wsta=1, exc=0, selpc=1, flush=1, wcau=wepc=0; next state REDIR.
REQ-026 MTC0 accept: mtc0=1; exactly one of wsta/wcau/wepc=1 per c0_rd 12/13/14; no write for any other index; no flush; FSM stays IDLE.
REQ-027 MFC0: mfc0 = 1/2/3 for c0_rd 12/13/14 when mfc0_req&ex_valid, else 0; combinational, valid in every state.
REQ-028 REDIR lasts 1 cycle, then HOLD for FLUSH_CYCLES-1 cycles (FLUSH_CYCLES=1 returns directly to IDLE); flush=1 throughout; busy=1 outside IDLE.
REQ-029 Outside IDLE all events are ignored: no write enables asserted, selpc=0; intr stays pending at source and is taken on the first IDLE cycle that meets REQ-021.
REQ-030 Masked events: no action; the instruction proceeds as normal.
REQ-031 ex_valid=0: every event input is ignored.

Reset
REQ-032 With rst=0 at an edge: state IDLE, counter 0, including mid-REDIR/HOLD.
REQ-033 While in reset and on the following cycle: wsta, wcau, wepc, exc, inta, mtc0, flush, busy = 0; selpc=0, mfc0=0, cause=0.

Structure
REQ-034 Shared package cp0_pkg holds: state enum; ExcCode constants 0/8/10/12; CP0 index constants 12/13/14; selpc and mfc0 encodings; vector 0x0000_0004.
REQ-035 One sub-module, cp0_exc_prio: combinational priority encoder producing accept flags and ExcCode.

Verification
REQ-036 sta=0x0F, ex_valid=1, ov=1 -> same cycle: cause=0x30, wsta=wcau=wepc=1, exc=1, selpc=2, inta=0; flush high 2 cycles; busy high 2 cycles.
REQ-037 sta=0x0F, intr=1 and syscall=1 together -> cause=0x00, inta=1 for one cycle; syscall ignored.
REQ-038 eret with ex_valid=1 in IDLE -> wsta=1, exc=0, selpc=1, flush for FLUSH_CYCLES cycles; wcau=wepc=0.
REQ-039 mtc0_req with c0_rd=13 -> mtc0=1, wcau=1, wsta=wepc=0, flush=0; c0_rd=5 -> no write enable.
REQ-040 ov accepted, then intr raised during HOLD -> no action until IDLE, then interrupt taken; rst=0 in REDIR -> IDLE next cycle, all outputs 0.
